serial_adder_nbit: RTL and testbench

SERIAL_ADDER_NBIT -- requirements
Module: serial_adder_nbit

---
 rtl/serial_adder_nbit.sv | 102 ++++++++++
 tb/tb_serial_adder_nbit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB slice first.
// Result registers only update on completion, so sum never shows a partial value.
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] ra, rb, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;
  logic [CHUNK:0]   s;
  logic             msb_ci;

  assign last = (cnt == CW'(N - 1));

  assign s = {1'b0, ra[CHUNK-1:0]}
           + {1'b0, rb[CHUNK-1:0]}
           + {{CHUNK{1'b0}}, carry};

  // carry into the top bit of the slice, recovered from its sum bit
  assign msb_ci = ra[CHUNK-1] ^ rb[CHUNK-1] ^ s[CHUNK-1];

  generate
    if (N == 1) begin : g_one
      assign acc_n = s[CHUNK-1:0];
    end else begin : g_many
      assign acc_n = {s[CHUNK-1:0], acc[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (state != RUN && start) begin
        ra    <= a;
        rb    <= sub ? ~b : b;
        carry <= sub ? 1'b1 : c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        ra    <= ra >> CHUNK;
        rb    <= rb >> CHUNK;
        acc   <= acc_n;
        carry <= s[CHUNK];
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum   <= acc_n;
          c_out <= s[CHUNK];
          ovf   <= msb_ci ^ s[CHUNK];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: several WIDTH/CHUNK builds driven in lockstep,
// directed corner cases plus random operands against an arithmetic model.
module tb_serial_adder_nbit;

  localparam int NC = 11;

  function automatic int cfg_w(int i);
    case (i)
      0, 1, 2:    return 4;
      3, 4, 5, 6: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic int cfg_c(int i);
    case (i)
      0: return 1;  1: return 2;  2: return 4;
      3: return 1;  4: return 2;  5: return 4;  6: return 8;
      7: return 1;  8: return 2;  9: return 4;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst, start, c_in, sub;
  logic [15:0] a_d, b_d;
  logic        busy_o [NC];
  logic        done_o [NC];
  logic        cout_o [NC];
  logic        ovf_o  [NC];
  logic [15:0] sum_o  [NC];

  int last_sum [NC];
  int last_co  [NC];
  int last_ov  [NC];

  generate
    for (genvar g = 0; g < NC; g++) begin : gi
      localparam int W = cfg_w(g);
      localparam int C = cfg_c(g);
      logic [W-1:0] s;
      serial_adder_nbit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_d[W-1:0]),
        .b     (b_d[W-1:0]),
        .c_in  (c_in),
        .sub   (sub),
        .busy  (busy_o[g]),
        .done  (done_o[g]),
        .sum   (s),
        .c_out (cout_o[g]),
        .ovf   (ovf_o[g])
      );
      assign sum_o[g] = 16'(s);
    end
  endgenerate

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(int w, int a, int b, bit ci, bit sb,
                                output int s, output bit co, output bit ov);
    int m;
    int r;
    bit sa, sbb, sr;
    m = (1 << w) - 1;
    a = a & m;
    b = b & m;
    if (sb) begin
      r  = a - b;
      co = (a >= b);
    end else begin
      r  = a + b + int'(ci);
      co = ((r >> w) & 1) != 0;
    end
    s   = r & m;
    sa  = ((a >> (w - 1)) & 1) != 0;
    sbb = ((b >> (w - 1)) & 1) != 0;
    sr  = ((s >> (w - 1)) & 1) != 0;
    ov  = sb ? (sa != sbb && sr != sa) : (sa == sbb && sr != sa);
  endfunction

  task automatic run_op(int a, int b, bit ci, bit sb);
    int nd [NC];
    int es;
    bit eco, eov;
    foreach (nd[k]) nd[k] = 0;
    a_d = 16'(a); b_d = 16'(b); c_in = ci; sub = sb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_d = 16'($urandom); b_d = 16'($urandom);
    c_in = 1'($urandom); sub = 1'($urandom);
    for (int cyc = 0; cyc <= 20; cyc++) begin
      for (int k = 0; k < NC; k++) begin
        if (done_o[k]) begin
          nd[k]++;
          model(cfg_w(k), a, b, ci, sb, es, eco, eov);
          chk($sformatf("lat w%0d c%0d", cfg_w(k), cfg_c(k)),
              cyc, cfg_w(k) / cfg_c(k));
          chk($sformatf("sum w%0d c%0d", cfg_w(k), cfg_c(k)), sum_o[k], es);
          chk($sformatf("cout w%0d c%0d", cfg_w(k), cfg_c(k)), cout_o[k], eco);
          chk($sformatf("ovf w%0d c%0d", cfg_w(k), cfg_c(k)), ovf_o[k], eov);
          last_sum[k] = int'(sum_o[k]);
          last_co[k]  = int'(cout_o[k]);
          last_ov[k]  = int'(ovf_o[k]);
        end
      end
      tick();
    end
    for (int k = 0; k < NC; k++)
      chk($sformatf("ndone w%0d c%0d", cfg_w(k), cfg_c(k)), nd[k], 1);
  endtask

  task automatic settle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd, dc0, dc1, s0, s1;
    rst = 1'b1; start = 1'b0; a_d = '0; b_d = '0; c_in = 1'b0; sub = 1'b0;
    tick(); tick();
    for (int k = 0; k < NC; k++) begin
      chk("rst busy", busy_o[k], 0);
      chk("rst done", done_o[k], 0);
      chk("rst sum", sum_o[k], 0);
      chk("rst cout", cout_o[k], 0);
      chk("rst ovf", ovf_o[k], 0);
    end
    rst = 1'b0;
    tick();

    // 0x0F + 0x01 on the 8/1 build, cycle by cycle
    a_d = 16'h0F; b_d = 16'h01; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy run%0d", i), busy_o[3], 1);
      chk($sformatf("done run%0d", i), done_o[3], 0);
      chk($sformatf("sum hold%0d", i), sum_o[3], 0);
      tick();
    end
    chk("d1 done", done_o[3], 1);
    chk("d1 busy", busy_o[3], 0);
    chk("d1 sum", sum_o[3], 16'h10);
    chk("d1 cout", cout_o[3], 0);
    chk("d1 ovf", ovf_o[3], 0);
    settle(20);

    run_op(16'h7F, 16'h01, 1'b0, 1'b0);
    chk("d2 sum", last_sum[3], 16'h80);
    chk("d2 cout", last_co[3], 0);
    chk("d2 ovf", last_ov[3], 1);
    run_op(16'hFF, 16'h01, 1'b1, 1'b0);
    chk("d3 sum", last_sum[3], 16'h01);
    chk("d3 cout", last_co[3], 1);
    chk("d3 ovf", last_ov[3], 0);
    run_op(16'h05, 16'h07, 1'b1, 1'b1);
    chk("d4 sum", last_sum[5], 16'hFE);
    chk("d4 cout", last_co[5], 0);
    chk("d4 ovf", last_ov[5], 0);
    run_op(16'h80, 16'h01, 1'b0, 1'b1);
    chk("d5 sum", last_sum[5], 16'h7F);
    chk("d5 cout", last_co[5], 1);
    chk("d5 ovf", last_ov[5], 1);

    // start pulse mid-run must be ignored by the 8/1 build
    a_d = 16'h3C; b_d = 16'h21; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc == 3) begin
        a_d = 16'hFF; b_d = 16'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_o[3]) begin
        nd++;
        chk("ign lat", cyc, 8);
        chk("ign sum", sum_o[3], 16'h5D);
      end
      tick();
    end
    chk("ign ndone", nd, 1);
    settle(20);

    // start held high: back-to-back operations
    a_d = 16'h11; b_d = 16'h22; start = 1'b1;
    tick();
    nd = 0; dc0 = -1; dc1 = -1; s0 = 0; s1 = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (done_o[3]) begin
        if (nd == 0) begin
          dc0 = cyc; s0 = int'(sum_o[3]);
          a_d = 16'h40; b_d = 16'h05;
        end else if (nd == 1) begin
          dc1 = cyc; s1 = int'(sum_o[3]);
        end
        nd++;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b first lat", dc0, 8);
    chk("b2b first sum", s0, 16'h33);
    chk("b2b second lat", dc1, 17);
    chk("b2b second sum", s1, 16'h45);
    settle(20);

    // reset in the third run cycle aborts the operation
    a_d = 16'h12; b_d = 16'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy_o[3], 0);
    chk("abort done", done_o[3], 0);
    chk("abort sum", sum_o[3], 0);
    chk("abort cout", cout_o[3], 0);
    chk("abort ovf", ovf_o[3], 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o[3] || sum_o[3] != 0) nd++;
      tick();
    end
    chk("abort quiet", nd, 0);

    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst prio busy", busy_o[3], 0);
    tick();

    for (int t = 0; t < 40; t++)
      run_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
